// File: rtl/branch_predictor_pkg.sv
// Shared constants for the direct-mapped branch predictor: counter states,
// RecoverD encodings and default geometry.
package branch_predictor_pkg;

  localparam int ENTRIES_DEF = 16;
  localparam int IDXW_DEF    = 4;

  localparam logic [1:0] CNT_SNT = 2'd0;
  localparam logic [1:0] CNT_WNT = 2'd1;
  localparam logic [1:0] CNT_WT  = 2'd2;
  localparam logic [1:0] CNT_ST  = 2'd3;

  localparam logic [1:0] REC_NONE   = 2'b00;
  localparam logic [1:0] REC_BRANCH = 2'b01;
  localparam logic [1:0] REC_PLUS4  = 2'b10;
  localparam logic [1:0] REC_JUMP   = 2'b11;

  function automatic logic cnt_predicts_taken(input logic [1:0] cnt);
    return (cnt >= CNT_WT);
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Two-bit saturating up/down counter, combinational next-state only.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       inc,
  output logic [1:0] cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (inc) begin
      if (cnt != CNT_ST) cnt_next = cnt + 2'd1;
      else               cnt_next = CNT_ST;
    end else begin
      if (cnt != CNT_SNT) cnt_next = cnt - 2'd1;
      else                cnt_next = CNT_SNT;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target predictor: zero-cycle lookup on PCF, recovery
// decision in decode, single-write-port flop table trained from decode.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = ENTRIES_DEF,
  parameter int IDXW    = IDXW_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic [31:0] PCBranchD,
  input  logic [31:0] PCJumpD,
  input  logic        BranchD,
  input  logic        JumpD,
  input  logic        ConditionD,
  output logic        PredTakenF,
  output logic [31:0] PCCache,
  output logic [1:0]  RecoverD,
  output logic [31:0] MispredictCount
);

  localparam int TAGW = 30 - IDXW;

  logic            valid_q  [ENTRIES];
  logic            valid_d  [ENTRIES];
  logic [TAGW-1:0] tag_q    [ENTRIES];
  logic [TAGW-1:0] tag_d    [ENTRIES];
  logic [31:0]     target_q [ENTRIES];
  logic [31:0]     target_d [ENTRIES];
  logic [1:0]      cnt_q    [ENTRIES];
  logic [1:0]      cnt_d    [ENTRIES];

  logic        pred_taken_q, pred_taken_d;
  logic [31:0] pred_target_q, pred_target_d;
  logic [31:0] mis_cnt_q, mis_cnt_d;

  logic [IDXW-1:0] f_idx, d_idx;
  logic [TAGW-1:0] f_tag, d_tag;
  logic            hit_f, hit_d;
  logic [1:0]      cnt_upd;
  logic [1:0]      recover;

  logic            wr_en, wr_valid;
  logic [31:0]     wr_target;
  logic [1:0]      wr_cnt;
  logic            unused_bits;

  assign unused_bits = ^{StallF, PCPlus4D, PCF[1:0], PCD[1:0]};

  assign f_idx = PCF[IDXW+1:2];
  assign f_tag = PCF[31:IDXW+2];
  assign d_idx = PCD[IDXW+1:2];
  assign d_tag = PCD[31:IDXW+2];

  assign hit_f = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign hit_d = valid_q[d_idx] && (tag_q[d_idx] == d_tag);

  // Lookup reads the registered table, so a same-cycle update is not visible yet.
  assign PredTakenF      = !reset && hit_f && cnt_predicts_taken(cnt_q[f_idx]);
  assign PCCache         = reset ? 32'd0 : target_q[f_idx];
  assign RecoverD        = recover;
  assign MispredictCount = mis_cnt_q;

  sat_counter2 u_sat_counter2 (
    .cnt      (cnt_q[d_idx]),
    .inc      (ConditionD),
    .cnt_next (cnt_upd)
  );

  always_comb begin
    recover = REC_NONE;
    if (reset || StallD) begin
      recover = REC_NONE;
    end else if (BranchD) begin
      if (ConditionD && (!pred_taken_q || (pred_target_q != PCBranchD))) recover = REC_BRANCH;
      else if (!ConditionD && pred_taken_q)                              recover = REC_PLUS4;
      else                                                               recover = REC_NONE;
    end else if (JumpD) begin
      if (!pred_taken_q || (pred_target_q != PCJumpD)) recover = REC_JUMP;
      else                                             recover = REC_NONE;
    end else if (pred_taken_q) begin
      recover = REC_PLUS4;
    end else begin
      recover = REC_NONE;
    end
  end

  always_comb begin
    wr_en     = 1'b0;
    wr_valid  = 1'b0;
    wr_target = target_q[d_idx];
    wr_cnt    = cnt_q[d_idx];
    if (StallD) begin
      wr_en = 1'b0;
    end else if (BranchD) begin
      if (hit_d) begin
        wr_en    = 1'b1;
        wr_valid = 1'b1;
        wr_cnt   = cnt_upd;
        if (ConditionD) wr_target = PCBranchD;
        else            wr_target = target_q[d_idx];
      end else if (ConditionD) begin
        wr_en     = 1'b1;
        wr_valid  = 1'b1;
        wr_cnt    = CNT_WT;
        wr_target = PCBranchD;
      end else begin
        wr_en = 1'b0;
      end
    end else if (JumpD) begin
      wr_en     = 1'b1;
      wr_valid  = 1'b1;
      wr_cnt    = CNT_ST;
      wr_target = PCJumpD;
    end else if (pred_taken_q && hit_d) begin
      // A predicted-taken non-branch means the entry aliased; drop it.
      wr_en    = 1'b1;
      wr_valid = 1'b0;
    end else begin
      wr_en = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (wr_en && (d_idx == i[IDXW-1:0])) begin
        valid_d[i]  = wr_valid;
        tag_d[i]    = d_tag;
        target_d[i] = wr_target;
        cnt_d[i]    = wr_cnt;
      end else begin
        valid_d[i]  = valid_q[i];
        tag_d[i]    = tag_q[i];
        target_d[i] = target_q[i];
        cnt_d[i]    = cnt_q[i];
      end
    end
  end

  always_comb begin
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    if (FlushD) begin
      pred_taken_d = 1'b0;
    end else if (!StallD) begin
      pred_taken_d  = PredTakenF;
      pred_target_d = PCCache;
    end else begin
      pred_taken_d = pred_taken_q;
    end
    if (recover != REC_NONE) mis_cnt_d = mis_cnt_q + 32'd1;
    else                     mis_cnt_d = mis_cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        cnt_q[i]    <= CNT_WNT;
      end
      pred_taken_q  <= 1'b0;
      pred_target_q <= 32'd0;
      mis_cnt_q     <= 32'd0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= valid_d[i];
        tag_q[i]    <= tag_d[i];
        target_q[i] <= target_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
      mis_cnt_q     <= mis_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF;
  logic        StallF, StallD, FlushD;
  logic [31:0] PCD, PCPlus4D, PCBranchD, PCJumpD;
  logic        BranchD, JumpD, ConditionD;
  logic        PredTakenF;
  logic [31:0] PCCache;
  logic [1:0]  RecoverD;
  logic [31:0] MispredictCount;

  int total = 0;
  int bad   = 0;

  branch_predictor dut (
    .clk(clk), .reset(reset), .PCF(PCF), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .PCD(PCD), .PCPlus4D(PCPlus4D), .PCBranchD(PCBranchD),
    .PCJumpD(PCJumpD), .BranchD(BranchD), .JumpD(JumpD), .ConditionD(ConditionD),
    .PredTakenF(PredTakenF), .PCCache(PCCache), .RecoverD(RecoverD),
    .MispredictCount(MispredictCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic d_idle(input logic [31:0] pc);
    PCD = pc; PCPlus4D = pc + 32'd4; BranchD = 1'b0; JumpD = 1'b0; ConditionD = 1'b0;
    PCBranchD = 32'd0; PCJumpD = 32'd0;
  endtask

  task automatic d_br(input logic [31:0] pc, input logic [31:0] tgt, input logic cond);
    PCD = pc; PCPlus4D = pc + 32'd4; BranchD = 1'b1; JumpD = 1'b0; ConditionD = cond;
    PCBranchD = tgt; PCJumpD = 32'd0;
  endtask

  task automatic d_j(input logic [31:0] pc, input logic [31:0] tgt);
    PCD = pc; PCPlus4D = pc + 32'd4; BranchD = 1'b0; JumpD = 1'b1; ConditionD = 1'b0;
    PCBranchD = 32'd0; PCJumpD = tgt;
  endtask

  initial begin
    reset = 1'b1; PCF = 32'h0040_0000; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    d_idle(32'h0);
    tick(); tick();
    chk("rst_predF", PredTakenF, 1'b0);
    chk("rst_cache", PCCache, 32'h0);
    chk("rst_recover", RecoverD, 2'b00);
    chk("rst_count", MispredictCount, 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_predF", PredTakenF, 1'b0);
    chk("post_rst_cnt4", dut.cnt_q[4], 2'd1);
    chk("post_rst_valid4", dut.valid_q[4], 1'b0);

    // Cold taken branch allocates entry 4
    d_br(32'h0040_0010, 32'h0040_0040, 1'b1); PCF = 32'h0040_0040; #1;
    chk("cold_br_recover", RecoverD, 2'b01);
    tick();
    chk("cold_br_cnt4", dut.cnt_q[4], 2'd2);
    chk("cold_br_count", MispredictCount, 32'd1);

    d_idle(32'h0040_0040); PCF = 32'h0040_0010; #1;
    chk("fetch_hit_predF", PredTakenF, 1'b1);
    chk("fetch_hit_cache", PCCache, 32'h0040_0040);
    chk("fetch_hit_recover", RecoverD, 2'b00);
    tick();

    d_br(32'h0040_0010, 32'h0040_0040, 1'b1); PCF = 32'h0040_0040; #1;
    chk("pred_ok_recover", RecoverD, 2'b00);
    tick();
    chk("taken2_cnt4", dut.cnt_q[4], 2'd3);

    d_idle(32'h0040_0040); PCF = 32'h0040_0010; #1;
    chk("taken3_fetch_predF", PredTakenF, 1'b1);
    tick();
    d_br(32'h0040_0010, 32'h0040_0040, 1'b1); PCF = 32'h0040_0010; #1;
    chk("taken3_recover", RecoverD, 2'b00);
    tick();
    chk("taken3_sat_cnt4", dut.cnt_q[4], 2'd3);

    // Not-taken while predicted taken; lookup in same cycle sees old counter
    d_br(32'h0040_0010, 32'h0040_0040, 1'b0); PCF = 32'h0040_0010; #1;
    chk("nt1_recover", RecoverD, 2'b10);
    chk("nt1_war_predF", PredTakenF, 1'b1);
    tick();
    chk("nt1_cnt4", dut.cnt_q[4], 2'd2);
    chk("nt1_count", MispredictCount, 32'd2);
    #1;
    chk("nt1_after_predF", PredTakenF, 1'b1);
    d_br(32'h0040_0010, 32'h0040_0040, 1'b0); PCF = 32'h0040_0000; #1;
    chk("nt2_recover", RecoverD, 2'b10);
    tick();
    chk("nt2_cnt4", dut.cnt_q[4], 2'd1);
    chk("nt2_count", MispredictCount, 32'd3);
    PCF = 32'h0040_0010; #1;
    chk("nt2_predF", PredTakenF, 1'b0);
    PCF = 32'h0040_0000;

    // Jump: cold then predicted
    d_j(32'h0040_0020, 32'h0040_0100); #1;
    chk("j1_recover", RecoverD, 2'b11);
    tick();
    chk("j1_cnt8", dut.cnt_q[8], 2'd3);
    chk("j1_count", MispredictCount, 32'd4);
    d_idle(32'h0040_0100); PCF = 32'h0040_0020; #1;
    chk("j_fetch_predF", PredTakenF, 1'b1);
    chk("j_fetch_cache", PCCache, 32'h0040_0100);
    tick();
    d_j(32'h0040_0020, 32'h0040_0100); PCF = 32'h0040_0000; #1;
    chk("j2_recover", RecoverD, 2'b00);
    tick();
    chk("j2_count", MispredictCount, 32'd4);

    // Aliasing PCs 0x00400010 / 0x00400050 share index 4
    d_br(32'h0040_0010, 32'h0040_0040, 1'b1); PCF = 32'h0040_0050; #1;
    chk("alias_br_recover", RecoverD, 2'b01);
    chk("alias_pre_predF", PredTakenF, 1'b0);
    tick();
    chk("alias_cnt4", dut.cnt_q[4], 2'd2);
    d_idle(32'h0040_0040); PCF = 32'h0040_0050; #1;
    chk("alias_miss_predF", PredTakenF, 1'b0);
    PCF = 32'h0040_0010; #1;
    chk("alias_own_predF", PredTakenF, 1'b1);
    PCF = 32'h0040_0000;
    tick();
    d_br(32'h0040_0050, 32'h0040_0080, 1'b1); #1;
    chk("alias_alloc_recover", RecoverD, 2'b01);
    tick();
    chk("alias_alloc_count", MispredictCount, 32'd6);
    d_idle(32'h0040_0040); PCF = 32'h0040_0010; #1;
    chk("alias_evicted_predF", PredTakenF, 1'b0);
    PCF = 32'h0040_0050; #1;
    chk("alias_new_predF", PredTakenF, 1'b1);
    chk("alias_new_cache", PCCache, 32'h0040_0080);
    tick();

    // Stale prediction on a non-branch invalidates the entry
    d_idle(32'h0040_0050); PCF = 32'h0040_0000; #1;
    chk("stale_recover", RecoverD, 2'b10);
    tick();
    chk("stale_valid4", dut.valid_q[4], 1'b0);
    chk("stale_count", MispredictCount, 32'd7);
    PCF = 32'h0040_0050; #1;
    chk("stale_predF", PredTakenF, 1'b0);

    // Stall holds everything in D
    StallD = 1'b1; d_br(32'h0040_0010, 32'h0040_0040, 1'b1); PCF = 32'h0040_0020;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_recover", RecoverD, 2'b00);
      tick();
      chk("stall_valid4", dut.valid_q[4], 1'b0);
      chk("stall_count", MispredictCount, 32'd7);
    end
    StallD = 1'b0; PCF = 32'h0040_0000; #1;
    chk("unstall_recover", RecoverD, 2'b01);
    tick();
    chk("unstall_cnt4", dut.cnt_q[4], 2'd2);
    chk("unstall_count", MispredictCount, 32'd8);

    // Flush clears the D-stage prediction
    d_idle(32'h0040_0040); PCF = 32'h0040_0020; FlushD = 1'b1;
    tick();
    chk("flush_ptd", dut.pred_taken_q, 1'b0);
    FlushD = 1'b0; d_idle(32'h0040_0024); PCF = 32'h0040_0000; #1;
    chk("flush_recover", RecoverD, 2'b00);
    tick();

    // Flush wins over stall hold
    d_idle(32'h0040_0040); PCF = 32'h0040_0020;
    tick();
    chk("pre_flush_ptd", dut.pred_taken_q, 1'b1);
    StallD = 1'b1; FlushD = 1'b1;
    tick();
    chk("flush_stall_ptd", dut.pred_taken_q, 1'b0);
    StallD = 1'b0; FlushD = 1'b0; PCF = 32'h0040_0000; #1;
    chk("flush_stall_recover", RecoverD, 2'b00);
    chk("flush_stall_count", MispredictCount, 32'd8);
    tick();

    // Reset arriving during an update discards it
    d_br(32'h0040_0030, 32'h0040_0200, 1'b1); PCF = 32'h0040_0020; #1;
    reset = 1'b1; #1;
    chk("midrst_recover", RecoverD, 2'b00);
    chk("midrst_predF", PredTakenF, 1'b0);
    chk("midrst_cache", PCCache, 32'h0);
    chk("midrst_count", MispredictCount, 32'd0);
    tick();
    chk("midrst_valid12", dut.valid_q[12], 1'b0);
    chk("midrst_cnt12", dut.cnt_q[12], 2'd1);
    reset = 1'b0; d_idle(32'h0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of direct-mapped entries (power of two, 4..64).
REQ-002 SHALL have parameter IDXW, default 4, log2(ENTRIES); index is PC[IDXW+1:2], tag is PC[31:IDXW+2].
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 PCF  in  32  fetch-stage PC being looked up.
REQ-006 StallF, StallD, FlushD  in  1 each  hazard-unit controls for the F and D stages.
REQ-007 PCD, PCPlus4D, PCBranchD, PCJumpD  in  32 each  decode-stage addresses from datapath.
REQ-008 BranchD, JumpD, ConditionD  in  1 each  decode-stage branch/jump flags and resolved condition.
REQ-009 PredTakenF  out  1  fetch prediction: redirect to PCCache next cycle.
REQ-010 PCCache  out  32  predicted target for PCF.
REQ-011 RecoverD  out  2  00 none, 01 redirect to PCBranchD, 10 redirect to PCPlus4D, 11 redirect to PCJumpD.
REQ-012 MispredictCount  out  32  number of recoveries signalled since reset.

Function
REQ-013 Entry SHALL hold valid, tag, 32-bit target, 2-bit saturating counter (0 SNT, 1 WNT, 2 WT, 3 ST).
REQ-014 Lookup SHALL be combinational on PCF: hit = valid and tag match; PredTakenF = hit and counter>=2; PCCache = entry target (don't-care when PredTakenF=0).
REQ-015 PredTakenF and PCCache SHALL be registered into PredTakenD/PredTargetD when StallD=0; FlushD=1 SHALL clear PredTakenD to 0 (FlushD takes priority over stall hold).
REQ-016 RecoverD with BranchD=1: ConditionD=1 and (PredTakenD=0 or PredTargetD!=PCBranchD) -> 01; ConditionD=0 and PredTakenD=1 -> 10; else 00.
REQ-017 RecoverD with JumpD=1: PredTakenD=0 or PredTargetD!=PCJumpD -> 11; else 00.
REQ-018 RecoverD with BranchD=0 and JumpD=0: PredTakenD=1 -> 10 (stale alias); else 00.
REQ-019 RecoverD SHALL be forced to 00 while StallD=1.
REQ-020 Update SHALL occur on the clock edge when StallD=0 and (BranchD or JumpD), indexed/tagged by PCD.
REQ-021 Branch, hit: counter +1 if ConditionD else -1, saturating at 3 and 0; target <= PCBranchD when taken.
REQ-022 Branch, miss, taken: allocate (overwrite) with counter=2, target=PCBranchD; miss, not taken: no change.
REQ-023 Jump: allocate or overwrite with counter=3, target=PCJumpD.
REQ-024 Non-branch PCD with PredTakenD=1 and StallD=0: invalidate that entry if tag matches.
REQ-025 Same-index lookup and update in one cycle: lookup SHALL see pre-update contents (write-after-read).
REQ-026 MispredictCount SHALL increment by 1 each cycle RecoverD!=00, wrapping 0xFFFFFFFF -> 0.
REQ-027 Latency: prediction zero-cycle from PCF; recovery signalled in D, one cycle after fetch.

Reset
REQ-028 reset=1 SHALL asynchronously clear all valid bits, counters to 1, PredTakenD 0, PredTargetD 0, MispredictCount 0.
REQ-029 While reset=1: PredTakenF=0, PCCache=0, RecoverD=00; reset mid-update SHALL discard the update.

Structure
REQ-030 Shared package SHALL hold counter-state constants, RecoverD encodings, default ENTRIES/IDXW.
REQ-031 One sub-module sat_counter2 (2-bit saturating increment/decrement, combinational next-state) SHALL be used per update path.
REQ-032 Storage SHALL be flops (no RAM macro), at most one write port.

Verification
REQ-033 Reset, PCF=0x00400000 -> PredTakenF=0, RecoverD=00, MispredictCount=0.
REQ-034 Taken beq at PCD=0x00400010, PCBranchD=0x00400040, cold -> RecoverD=01, entry idx 4 counter=2; next fetch of 0x00400010 -> PredTakenF=1, PCCache=0x00400040.
REQ-035 Same branch taken x3 then not-taken x1 -> counter 3 then 2, PredTakenF stays 1; second not-taken -> counter 1, RecoverD=10 each not-taken while predicted taken.
REQ-036 j at PCD=0x00400020 -> RecoverD=11 first time, 00 on second encounter; counter=3.
REQ-037 Alias: PCs 0x00400010 and 0x00400050 (same index) alternate -> tag mismatch gives miss, no false PredTakenF.
REQ-038 StallD=1 with taken branch in D for 3 cycles -> no counter change, RecoverD=00 until StallD=0; FlushD=1 -> PredTakenD cleared.
